pipe_block_adder: RTL and testbench

- Parametrised, fully pipelined block adder/subtractor. Generalises the fixed 64-bit, 8-block adder.
- Operands are split into NBLK blocks of BLK bits. One block is added per pipeline stage, and the carry is registered between stages.
- Adds a valid qualifier, a pipeline-advance enable, a subtract mode and signed-overflow detection.
- Throughput is one operation per cycle, with latency of NBLK cycles. Sits in the datapath wherever wide adds must close timing at the block clock.

---
 rtl/pipe_block_adder.sv | 89 ++++++++
 tb/tb_pipe_block_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_block_adder.sv
// Pipelined block adder/subtractor: one BLK-bit block per stage, carry registered between
// stages, operands skewed in and sum blocks carried along so a whole result emerges at once.
module pipe_block_adder #(
   parameter int WIDTH = 64,
   parameter int BLK   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NBLK = WIDTH / BLK;

   logic [WIDTH-1:0] a_q [NBLK];
   logic [WIDTH-1:0] b_q [NBLK];
   logic [WIDTH-1:0] s_q [NBLK];
   logic             c_q [NBLK];
   logic             v_q [NBLK];

   logic [WIDTH-1:0] a_in  [NBLK];
   logic [WIDTH-1:0] b_in  [NBLK];
   logic [WIDTH-1:0] s_in  [NBLK];
   logic             c_in  [NBLK];
   logic             v_in  [NBLK];
   logic [WIDTH-1:0] s_nxt [NBLK];
   logic             c_nxt [NBLK];
   logic [BLK:0]     blk_sum;

   // Stage k consumes what stage k-1 registered; stage 0 takes the ports with b/cin
   // inverted for subtract so every stage is a plain add.
   always_comb begin
      blk_sum = '0;
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      c_in[0] = sub ? ~cin : cin;
      s_in[0] = '0;
      v_in[0] = in_valid;
      for (int k = 1; k < NBLK; k++) begin
         a_in[k] = a_q[k-1];
         b_in[k] = b_q[k-1];
         c_in[k] = c_q[k-1];
         s_in[k] = s_q[k-1];
         v_in[k] = v_q[k-1];
      end
      for (int k = 0; k < NBLK; k++) begin
         blk_sum = {1'b0, a_in[k][k*BLK +: BLK]} + {1'b0, b_in[k][k*BLK +: BLK]}
                 + {{BLK{1'b0}}, c_in[k]};
         s_nxt[k] = s_in[k];
         s_nxt[k][k*BLK +: BLK] = blk_sum[BLK-1:0];
         c_nxt[k] = blk_sum[BLK];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NBLK; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
      end else if (en) begin
         for (int k = 0; k < NBLK; k++) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
            v_q[k] <= v_in[k];
         end
      end
   end

   assign out_valid = v_q[NBLK-1];
   assign sum       = s_q[NBLK-1];
   assign cout      = c_q[NBLK-1];
   // Same-sign operands giving an opposite-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
   assign ovf = ~(a_q[NBLK-1][WIDTH-1] ^ b_q[NBLK-1][WIDTH-1])
              & (s_q[NBLK-1][WIDTH-1] ^ a_q[NBLK-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_block_adder.sv
// Bench for pipe_block_adder: three configurations (64/8, 32/4, 64/64) driven in parallel
// and compared against an arithmetic model of the captured operation stream.
module tb_pipe_block_adder;
   logic        clk = 1'b0;
   logic        rst, en, in_valid, sub, cin;
   logic [63:0] a, b;

   always #5 clk = ~clk;

   logic        v0, c0, o0, v1, c1, o1, v2, c2, o2;
   logic [63:0] s0, s2;
   logic [31:0] s1;

   pipe_block_adder #(.WIDTH(64), .BLK(8)) u_d64 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .a(a), .b(b), .cin(cin),
      .out_valid(v0), .sum(s0), .cout(c0), .ovf(o0));
   pipe_block_adder #(.WIDTH(32), .BLK(4)) u_d32 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .a(a[31:0]), .b(b[31:0]),
      .cin(cin), .out_valid(v1), .sum(s1), .cout(c1), .ovf(o1));
   pipe_block_adder #(.WIDTH(64), .BLK(64)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .a(a), .b(b), .cin(cin),
      .out_valid(v2), .sum(s2), .cout(c2), .ovf(o2));

   logic        o_v [3];
   logic [63:0] o_s [3];
   logic        o_c [3];
   logic        o_o [3];
   always_comb begin
      o_v[0] = v0; o_s[0] = s0;          o_c[0] = c0; o_o[0] = o0;
      o_v[1] = v1; o_s[1] = {32'b0, s1}; o_c[1] = c1; o_o[1] = o1;
      o_v[2] = v2; o_s[2] = s2;          o_c[2] = c2; o_o[2] = o2;
   end

   int lat [3] = '{8, 8, 1};
   int wd  [3] = '{64, 32, 64};
   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        v;
      logic        s;
      logic [63:0] a;
      logic [63:0] b;
      logic        c;
   } op_t;

   typedef struct {
      logic        v;
      logic [63:0] s;
      logic        c;
      logic        o;
   } res_t;

   op_t cap [$];

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic res_t model(op_t op, int w);
      logic [63:0]        mask;
      logic [67:0]        ua, ub, uc, u, modw;
      logic signed [67:0] sa, sb, ci, r, lim;
      res_t               res;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ua   = {4'b0, op.a & mask};
      ub   = {4'b0, op.b & mask};
      uc   = {67'b0, op.c};
      modw = 68'd1 << w;
      sa   = $signed(ua);
      sb   = $signed(ub);
      if (op.a[w-1]) sa = sa - $signed(modw);
      if (op.b[w-1]) sb = sb - $signed(modw);
      ci   = $signed(uc);
      lim  = $signed(68'd1 << (w - 1));
      if (!op.s) begin
         u     = ua + ub + uc;
         res.c = (u >= modw);
         r     = sa + sb + ci;
      end else begin
         u     = ua - ub - uc;
         res.c = (ua >= ub + uc);
         r     = sa - sb - ci;
      end
      res.s = u[63:0] & mask;
      res.o = (r >= lim) || (r < -lim);
      res.v = op.v;
      return res;
   endfunction

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         res_t e;
         e = '{v: 1'b0, s: '0, c: 1'b0, o: 1'b0};
         if (cap.size() >= lat[i]) e = model(cap[cap.size() - lat[i]], wd[i]);
         chk($sformatf("d%0d_valid", i), {63'b0, o_v[i]}, {63'b0, e.v});
         if (e.v) begin
            chk($sformatf("d%0d_sum", i),  o_s[i], e.s);
            chk($sformatf("d%0d_cout", i), {63'b0, o_c[i]}, {63'b0, e.c});
            chk($sformatf("d%0d_ovf", i),  {63'b0, o_o[i]}, {63'b0, e.o});
         end
      end
   endtask

   task automatic check_zero(string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_d%0d_valid", tag, i), {63'b0, o_v[i]}, 64'd0);
         chk($sformatf("%s_d%0d_sum", tag, i),   o_s[i], 64'd0);
         chk($sformatf("%s_d%0d_cout", tag, i),  {63'b0, o_c[i]}, 64'd0);
         chk($sformatf("%s_d%0d_ovf", tag, i),   {63'b0, o_o[i]}, 64'd0);
      end
   endtask

   // Drive at the falling edge, let the rising edge capture, check at the next falling edge.
   task automatic step(logic v, logic s, logic [63:0] aa, logic [63:0] bb, logic cc, logic e);
      in_valid = v; sub = s; a = aa; b = bb; cin = cc; en = e;
      @(posedge clk);
      if (e && rst) cap.push_back('{v: v, s: s, a: aa, b: bb, c: cc});
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 9))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         3:       return 64'h8000_0000_0000_0000;
         4:       return 64'h0000_0000_7FFF_FFFF;
         5:       return 64'h0000_0000_8000_0000;
         6:       return 64'd1;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   initial begin
      rst = 1'b0; en = 1'b1; in_valid = 1'b1; sub = 1'b0; cin = 1'b1;
      a = 64'h1234; b = 64'h5678;
      @(negedge clk); @(negedge clk);
      check_zero("rst_init");
      rst = 1'b1;
      in_valid = 1'b0;

      // basic add, full ripple, signed overflow (add and subtract)
      step(1, 0, 64'd2, 64'd5, 0, 1);
      step(1, 0, '1, 64'd0, 1, 1);
      step(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1);
      step(1, 1, 64'h8000_0000_0000_0000, 64'd1, 0, 1);
      step(1, 0, 64'h0000_0000_7FFF_FFFF, 64'd1, 0, 1);
      step(1, 1, 64'h0000_0000_8000_0000, 64'd1, 0, 1);
      idle(9);

      // back-to-back, no carry sharing
      step(1, 0, 64'd1228, 64'd1238, 0, 1);
      step(1, 0, 64'd1228, 64'd1238, 1, 1);
      step(1, 0, 64'd128, 64'd128, 0, 1);
      step(1, 0, 64'd75, 64'd75, 1, 1);
      idle(9);

      // subtract
      step(1, 1, 64'd25623210, 64'd222340, 0, 1);
      step(1, 1, 64'd0, 64'd1, 0, 1);
      step(1, 1, 64'd20, 64'd20, 1, 1);
      idle(9);

      // stall with three results at or near the output
      step(1, 0, 64'd100, 64'd23, 0, 1);
      step(1, 1, 64'd100, 64'd23, 0, 1);
      step(1, 0, '1, '1, 1, 1);
      idle(5);
      for (int i = 0; i < 3; i++) step(1, 1, 64'hDEAD, 64'hBEEF, 1, 0);
      idle(9);

      // reset asserted mid-stream with valid inputs on both sides
      for (int i = 0; i < 10; i++) step(1, i[0], pick(), pick(), i[1], 1);
      in_valid = 1'b1; a = 64'd9; b = 64'd9;
      @(posedge clk);
      #3 rst = 1'b0;
      cap.delete();
      #1 check_zero("rst_async");
      @(negedge clk);
      check_all();
      step(1, 0, 64'd3, 64'd4, 0, 1);
      step(1, 0, 64'd3, 64'd4, 0, 1);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) step(1, 0, 64'd1000 + 64'(i), 64'd7, 0, 1);
      idle(9);

      // randomized mix of valid, subtract, carry-in and stalls
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick(), pick(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0));
      idle(9);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
